// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel prescaler, free-running column/line counters and
// registered sync / blanking / end-of-line / end-of-frame strobes aligned to the counters.
module vga_sync_gen #(
    parameter int CLK_DIV   = 2,
    parameter int H_DISPLAY = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_DISPLAY = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic       CLK,
    input  logic       RST,
    output logic       p_tick,
    output logic [9:0] ADDRH,
    output logic [9:0] ADDRV,
    output logic       HSYNC,
    output logic       VSYNC,
    output logic       video_ON,
    output logic       line_end,
    output logic       frame_end
);

    localparam int H_TOT = H_DISPLAY + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_DISPLAY + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
    localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
    localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             p_tick_q, p_tick_d;
    logic [9:0]       addrh_q, addrh_d;
    logic [9:0]       addrv_q, addrv_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             video_on_q, video_on_d;
    logic             line_end_q, line_end_d;
    logic             frame_end_q, frame_end_d;

    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        p_tick_d = (div_d == DIV_LAST);

        addrh_d = addrh_q;
        addrv_d = addrv_q;
        if (p_tick_q) begin
            if (addrh_q == H_LAST) begin
                addrh_d = '0;
                addrv_d = (addrv_q == V_LAST) ? '0 : addrv_q + 10'd1;
            end else begin
                addrh_d = addrh_q + 10'd1;
            end
        end

        // Decoded from the next counter values so the registered flags line up with ADDRH/ADDRV.
        hsync_d     = !((addrh_d >= HS_FIRST) && (addrh_d <= HS_LAST));
        vsync_d     = !((addrv_d >= VS_FIRST) && (addrv_d <= VS_LAST));
        video_on_d  = (addrh_d < H_VIS) && (addrv_d < V_VIS);
        line_end_d  = p_tick_d && (addrh_d == H_LAST);
        frame_end_d = line_end_d && (addrv_d == V_LAST);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            div_q       <= '0;
            p_tick_q    <= 1'b0;
            addrh_q     <= '0;
            addrv_q     <= '0;
            hsync_q     <= 1'b1;
            vsync_q     <= 1'b1;
            video_on_q  <= 1'b0;
            line_end_q  <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            div_q       <= div_d;
            p_tick_q    <= p_tick_d;
            addrh_q     <= addrh_d;
            addrv_q     <= addrv_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            video_on_q  <= video_on_d;
            line_end_q  <= line_end_d;
            frame_end_q <= frame_end_d;
        end
    end

    assign p_tick    = p_tick_q;
    assign ADDRH     = addrh_q;
    assign ADDRV     = addrv_q;
    assign HSYNC     = hsync_q;
    assign VSYNC     = vsync_q;
    assign video_ON  = video_on_q;
    assign line_end  = line_end_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (full 640x480 /2, reduced raster /2, full /1)
// checked every cycle against a pixel-index model, plus directed literal expectations.
module tb_vga_sync_gen;

    logic       CLK;
    logic [2:0] rst;
    logic [2:0] ptick, hs, vs, von, le, fe;
    logic [9:0] ah [3];
    logic [9:0] av [3];

    int checks = 0;
    int errors = 0;

    // Timing of each instance, indexed like the DUT arrays.
    int P_DIV [3] = '{2, 2, 1};
    int P_HD  [3] = '{640, 8, 640};
    int P_HFP [3] = '{16, 2, 16};
    int P_HSY [3] = '{96, 3, 96};
    int P_HBP [3] = '{48, 2, 48};
    int P_VD  [3] = '{480, 6, 480};
    int P_VFP [3] = '{10, 1, 10};
    int P_VSY [3] = '{2, 2, 2};
    int P_VBP [3] = '{33, 2, 33};

    vga_sync_gen #(.CLK_DIV(2)) u_a (
        .CLK(CLK), .RST(rst[0]), .p_tick(ptick[0]), .ADDRH(ah[0]), .ADDRV(av[0]),
        .HSYNC(hs[0]), .VSYNC(vs[0]), .video_ON(von[0]), .line_end(le[0]), .frame_end(fe[0])
    );

    vga_sync_gen #(
        .CLK_DIV(2), .H_DISPLAY(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_DISPLAY(6), .V_FP(1), .V_SYNC(2), .V_BP(2)
    ) u_b (
        .CLK(CLK), .RST(rst[1]), .p_tick(ptick[1]), .ADDRH(ah[1]), .ADDRV(av[1]),
        .HSYNC(hs[1]), .VSYNC(vs[1]), .video_ON(von[1]), .line_end(le[1]), .frame_end(fe[1])
    );

    vga_sync_gen #(.CLK_DIV(1)) u_c (
        .CLK(CLK), .RST(rst[2]), .p_tick(ptick[2]), .ADDRH(ah[2]), .ADDRV(av[2]),
        .HSYNC(hs[2]), .VSYNC(vs[2]), .video_ON(von[2]), .line_end(le[2]), .frame_end(fe[2])
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Model: k = CLK edges since release, pix = p_ticks completed before this cycle.
    int  k    [3];
    int  pix  [3];
    bit  prev [3];

    always @(negedge CLK) begin
        for (int i = 0; i < 3; i++) begin
            int  htot, vtot, h, v, e_hs, e_vs, e_von, e_le, e_fe, e_tick;
            if (!rst[i]) begin
                k[i] = 0; pix[i] = 0; prev[i] = 1'b0;
                h = 0; v = 0; e_tick = 0; e_hs = 1; e_vs = 1; e_von = 0; e_le = 0; e_fe = 0;
            end else begin
                if (prev[i]) pix[i]++;
                k[i]++;
                e_tick = (k[i] % P_DIV[i] == P_DIV[i] - 1) ? 1 : 0;
                htot = P_HD[i] + P_HFP[i] + P_HSY[i] + P_HBP[i];
                vtot = P_VD[i] + P_VFP[i] + P_VSY[i] + P_VBP[i];
                h = pix[i] % htot;
                v = (pix[i] / htot) % vtot;
                e_hs  = (h >= P_HD[i] + P_HFP[i] && h < P_HD[i] + P_HFP[i] + P_HSY[i]) ? 0 : 1;
                e_vs  = (v >= P_VD[i] + P_VFP[i] && v < P_VD[i] + P_VFP[i] + P_VSY[i]) ? 0 : 1;
                e_von = (h < P_HD[i] && v < P_VD[i]) ? 1 : 0;
                e_le  = (e_tick == 1 && h == htot - 1) ? 1 : 0;
                e_fe  = (e_le == 1 && v == vtot - 1) ? 1 : 0;
                prev[i] = (e_tick == 1);
            end
            chk($sformatf("dut%0d k%0d p_tick", i, k[i]), int'(ptick[i]), e_tick);
            chk($sformatf("dut%0d k%0d ADDRH", i, k[i]), int'(ah[i]), h);
            chk($sformatf("dut%0d k%0d ADDRV", i, k[i]), int'(av[i]), v);
            chk($sformatf("dut%0d k%0d HSYNC", i, k[i]), int'(hs[i]), e_hs);
            chk($sformatf("dut%0d k%0d VSYNC", i, k[i]), int'(vs[i]), e_vs);
            chk($sformatf("dut%0d k%0d video_ON", i, k[i]), int'(von[i]), e_von);
            chk($sformatf("dut%0d k%0d line_end", i, k[i]), int'(le[i]), e_le);
            chk($sformatf("dut%0d k%0d frame_end", i, k[i]), int'(fe[i]), e_fe);
        end
    end

    initial begin
        int a_hs_low, a_first_hs, a_first_voff, a_le;
        int c_hs_low, c_noptick, c_le;
        int b_von, b_vs_low, b_fe1, b_fe2, ticks;
        bit found;

        a_hs_low = 0; a_le = 0; c_hs_low = 0; c_noptick = 0; c_le = 0;
        b_von = 0; b_vs_low = 0; ticks = 0;
        a_first_hs = -1; a_first_voff = -1; b_fe1 = -1; b_fe2 = -1;

        rst = '0;
        repeat (10) @(negedge CLK);
        chk("reset ADDRH", int'(ah[0]), 0);
        chk("reset ADDRV", int'(av[0]), 0);
        chk("reset HSYNC", int'(hs[0]), 1);
        chk("reset VSYNC", int'(vs[0]), 1);
        chk("reset video_ON", int'(von[0]), 0);
        chk("reset pulses", int'({ptick[0], le[0], fe[0]}), 0);
        #1 rst = '1;

        for (int n = 1; n <= 3000; n++) begin
            @(negedge CLK);
            if (av[0] == 10'd0 && ptick[0] && !hs[0]) a_hs_low++;
            if (!hs[0] && a_first_hs < 0) a_first_hs = int'(ah[0]);
            if (!von[0] && a_first_voff < 0) a_first_voff = int'(ah[0]);
            if (le[0]) a_le++;
            if (av[2] == 10'd0 && !hs[2]) c_hs_low++;
            if (!ptick[2]) c_noptick++;
            if (le[2]) c_le++;
            if (n <= 330) begin
                if (ptick[1] && von[1]) b_von++;
                if (ptick[1] && !vs[1]) b_vs_low++;
            end
            if (fe[1]) begin
                if (b_fe1 < 0) b_fe1 = n;
                else if (b_fe2 < 0) b_fe2 = n;
            end
        end
        chk("a hsync low p_ticks", a_hs_low, 96);
        chk("a first hsync low ADDRH", a_first_hs, 656);
        chk("a first blank ADDRH", a_first_voff, 640);
        chk("a line_end count", a_le, 1);
        chk("c hsync low clks", c_hs_low, 96);
        chk("c p_tick gaps", c_noptick, 0);
        chk("c line_end count", c_le, 3);
        chk("b video_ON p_ticks", b_von, 48);
        chk("b vsync low p_ticks", b_vs_low, 30);
        chk("b first frame_end clk", b_fe1, 329);
        chk("b frame period clks", b_fe2 - b_fe1, 330);

        // Full-frame wrap on the reduced raster.
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge CLK);
            if (fe[1]) found = 1'b1;
        end
        chk("wrap frame_end seen", int'(found), 1);
        chk("wrap pre ADDRH", int'(ah[1]), 14);
        chk("wrap pre ADDRV", int'(av[1]), 10);
        @(posedge CLK);
        #1;
        chk("wrap ADDRH", int'(ah[1]), 0);
        chk("wrap ADDRV", int'(av[1]), 0);
        chk("wrap video_ON", int'(von[1]), 1);
        chk("wrap syncs", int'({hs[1], vs[1]}), 3);

        // Reset while both syncs are low.
        found = 1'b0;
        for (int n = 0; n < 400 && !found; n++) begin
            @(negedge CLK);
            if (ah[1] == 10'd11 && av[1] == 10'd8) found = 1'b1;
        end
        chk("midreset target seen", int'(found), 1);
        chk("midreset syncs low", int'({hs[1], vs[1]}), 0);
        #1 rst[1] = 1'b0;
        #1;
        chk("midreset HSYNC", int'(hs[1]), 1);
        chk("midreset VSYNC", int'(vs[1]), 1);
        chk("midreset ADDRH", int'(ah[1]), 0);
        chk("midreset ADDRV", int'(av[1]), 0);
        repeat (4) @(negedge CLK);
        #1 rst[1] = 1'b1;
        found = 1'b0;
        for (int n = 0; n < 100 && !found; n++) begin
            @(negedge CLK);
            if (ptick[1]) ticks++;
            if (!hs[1]) found = 1'b1;
        end
        chk("post-reset hsync fall seen", int'(found), 1);
        chk("post-reset p_ticks to hsync", ticks, 10);

        @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
